// File: rtl/div_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the divide issue controller.
package div_ctrl_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Divide-by-zero and signed-overflow detection with their architectural results.
module div_special_case
    import div_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [1:0]      op,
    input  logic            word,
    output logic            hit,
    output logic [XLEN-1:0] result
);

    logic            sgn;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rmd;

    always_comb begin
        sgn = op_signed(op);
        if (word) begin
            div0 = (src2[31:0] == 32'd0);
            ovf  = sgn && (src1[31:0] == MIN32) && (src2[31:0] == 32'hFFFF_FFFF);
            quo  = div0 ? '1 : sext32(src1[31:0]);
            rmd  = div0 ? sext32(src1[31:0]) : '0;
        end else begin
            div0 = (src2 == '0);
            ovf  = sgn && (src1 == MIN64) && (src2 == '1);
            quo  = div0 ? '1 : src1;
            rmd  = div0 ? src1 : '0;
        end
        hit    = div0 || ovf;
        result = op_is_rem(op) ? rmd : quo;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/complete sequencer for the shared iterative divider: special cases and
// cache hits are answered locally, everything else is sent to the divider.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN_P    = XLEN,
    parameter int TAG_W     = 5,
    parameter bit USE_CACHE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic              req_word,
    input  logic [XLEN_P-1:0] req_src1,
    input  logic [XLEN_P-1:0] req_src2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN_P-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              div_valid,
    input  logic              div_ready,
    output logic              div_divw,
    output logic              div_signed,
    output logic              div_flush,
    output logic [XLEN_P-1:0] div_dividend,
    output logic [XLEN_P-1:0] div_divisor,
    input  logic              div_out_valid,
    input  logic [XLEN_P-1:0] div_quotient,
    input  logic [XLEN_P-1:0] div_remainder
);

    state_t state, state_n;

    logic              accept;
    logic              req_sgn;
    logic              spc_hit;
    logic [XLEN-1:0]   spc_data;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_raw;
    logic [XLEN-1:0]   cache_data;
    logic              fast;
    logic [XLEN-1:0]   fast_data;
    logic              complete;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   div_data;

    // Key of the op currently at the divider, copied into the cache on completion.
    logic [XLEN-1:0]   p_src1, p_src2;
    logic              p_word, p_sgn, p_rem;

    logic              c_vld;
    logic [XLEN-1:0]   c_src1, c_src2, c_quo, c_rem;
    logic              c_word, c_sgn;

    div_special_case u_spc (
        .src1   (req_src1),
        .src2   (req_src2),
        .op     (req_op),
        .word   (req_word),
        .hit    (spc_hit),
        .result (spc_data)
    );

    assign req_sgn   = op_signed(req_op);
    assign req_ready = (state == IDLE) && div_ready && !flush && !rst;
    assign accept    = req_valid && req_ready;

    assign cache_hit  = USE_CACHE && c_vld && (req_src1 == c_src1) && (req_src2 == c_src2)
                        && (req_word == c_word) && (req_sgn == c_sgn);
    assign cache_raw  = op_is_rem(req_op) ? c_rem : c_quo;
    assign cache_data = req_word ? sext32(cache_raw[31:0]) : cache_raw;

    assign fast      = spc_hit || cache_hit;
    assign fast_data = spc_hit ? spc_data : cache_data;

    assign complete = (state == BUSY) && div_out_valid && !flush;
    assign div_raw  = p_rem ? div_remainder : div_quotient;
    assign div_data = p_word ? sext32(div_raw[31:0]) : div_raw;

    assign div_dividend = req_src1;
    assign div_divisor  = req_src2;
    assign div_divw     = req_word;
    assign div_signed   = req_sgn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        div_valid  = 1'b0;
        div_flush  = flush && (state == BUSY);
        resp_valid = (state == DONE) && !flush;
        case (state)
            IDLE: if (accept) begin
                state_n   = fast ? DONE : BUSY;
                div_valid = !fast;
            end
            BUSY: if (div_out_valid) state_n = DONE;
            DONE: if (resp_ready)    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= '0;
            resp_tag  <= '0;
            p_src1    <= '0;
            p_src2    <= '0;
            p_word    <= 1'b0;
            p_sgn     <= 1'b0;
            p_rem     <= 1'b0;
            c_vld     <= 1'b0;
            c_src1    <= '0;
            c_src2    <= '0;
            c_word    <= 1'b0;
            c_sgn     <= 1'b0;
            c_quo     <= '0;
            c_rem     <= '0;
        end else begin
            if (accept) begin
                resp_tag <= req_tag;
                p_src1   <= req_src1;
                p_src2   <= req_src2;
                p_word   <= req_word;
                p_sgn    <= req_sgn;
                p_rem    <= op_is_rem(req_op);
                if (fast) resp_data <= fast_data;
            end
            if (complete) begin
                resp_data <= div_data;
                c_vld     <= 1'b1;
                c_src1    <= p_src1;
                c_src2    <= p_src2;
                c_word    <= p_word;
                c_sgn     <= p_sgn;
                c_quo     <= div_quotient;
                c_rem     <= div_remainder;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed vector bench for div_issue_ctrl with a behavioural iterative divider.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] req_src1, req_src2;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        div_valid, div_ready, div_divw, div_signed, div_flush;
    logic [63:0] div_dividend, div_divisor;
    logic        div_out_valid;
    logic [63:0] div_quotient, div_remainder;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TAG_W(5), .USE_CACHE(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
        .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .div_valid(div_valid), .div_ready(div_ready), .div_divw(div_divw), .div_signed(div_signed),
        .div_flush(div_flush), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_out_valid(div_out_valid), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // Behavioural divider: 65 cycles for 64-bit ops, 33 for word ops.
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_q, m_r;
    assign div_ready = !m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_cnt <= 0; div_out_valid <= 1'b0;
            div_quotient <= '0; div_remainder <= '0;
        end else begin
            div_out_valid <= 1'b0;
            if (div_flush) begin
                m_busy <= 1'b0;
            end else if (div_valid && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= div_divw ? 33 : 65;
                if (div_divw) begin
                    logic [31:0] a, b, q, r;
                    a = div_dividend[31:0]; b = div_divisor[31:0];
                    if (b == 0) begin q = '1; r = a; end
                    else if (div_signed) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
                    else begin q = a / b; r = a % b; end
                    m_q <= {{32{q[31]}}, q}; m_r <= {{32{r[31]}}, r};
                end else begin
                    if (div_divisor == 0) begin m_q <= '1; m_r <= div_dividend; end
                    else if (div_signed) begin
                        m_q <= $signed(div_dividend) / $signed(div_divisor);
                        m_r <= $signed(div_dividend) % $signed(div_divisor);
                    end else begin
                        m_q <= div_dividend / div_divisor;
                        m_r <= div_dividend % div_divisor;
                    end
                end
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0; div_out_valid <= 1'b1;
                    div_quotient <= m_q; div_remainder <= m_r;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [4:0]  tag;
        logic [63:0] exp;
        logic        issue;
    } vec_t;

    vec_t vecs[10];

    // Present one request, wait for its response, check it and consume it.
    task automatic run_req(input vec_t v, input string name);
        int  n;
        logic issued, fast_seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = v.op; req_word = v.word;
        req_src1 = v.src1; req_src2 = v.src2; req_tag = v.tag;
        #1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); #1; n++; end
        chk({name, "_accept"}, {63'd0, req_ready}, 64'd1);
        issued = div_valid;
        @(posedge clk); #1;
        req_valid = 1'b0;
        fast_seen = resp_valid;
        n = 0;
        while (!resp_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk({name, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({name, "_issue"}, {63'd0, issued}, {63'd0, v.issue});
        if (!v.issue) chk({name, "_fast_latency"}, {63'd0, fast_seen}, 64'd1);
        chk({name, "_data"}, resp_data, v.exp);
        chk({name, "_tag"}, {59'd0, resp_tag}, {59'd0, v.tag});
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    task automatic issue_only(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_word = 1'b0;
        req_src1 = a; req_src2 = b; req_tag = 5'd9;
        #1;
        chk("issue_only_div_valid", {63'd0, div_valid}, 64'd1);
        @(posedge clk); #1; req_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        vecs[1] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 64'd5, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 64'd5, 64'd0, 5'd4, 64'd5, 1'b0};
        vecs[4] = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'h8000_0000_0000_0000, 1'b0};
        vecs[5] = '{2'b10, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd6, 64'd0, 1'b0};
        vecs[6] = '{2'b00, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        vecs[7] = '{2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[8] = '{2'b01, 1'b0, 64'd1000, 64'd3, 5'd10, 64'd333, 1'b1};
        vecs[9] = '{2'b11, 1'b0, 64'd1000, 64'd3, 5'd11, 64'd1, 1'b0};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_word = 1'b0;
        req_src1 = '0; req_src2 = '0; req_tag = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_div_valid", {63'd0, div_valid}, 64'd0);
        chk("rst_div_flush", {63'd0, div_flush}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_tag", {59'd0, resp_tag}, 64'd0);
        rst = 1'b0;
        #1 chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 10; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Flush ten cycles into a divider op; the divider is aborted and nothing returns.
        issue_only(2'b00, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1; #1;
        chk("flush_div_flush", {63'd0, div_flush}, 64'd1);
        chk("flush_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1; flush = 1'b0; #1;
        chk("flush_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("flush_idle", {63'd0, req_ready}, 64'd1);
        begin
            logic seen;
            seen = 1'b0;
            repeat (80) begin @(posedge clk); #1; seen = seen | resp_valid; end
            chk("flush_no_resp", {63'd0, seen}, 64'd0);
        end
        run_req('{2'b10, 1'b0, 64'd100, 64'd7, 5'd12, 64'd2, 1'b1}, "rem_after_flush");

        // Held response under backpressure.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_word = 1'b0; req_src1 = 64'd9; req_src2 = 64'd0; req_tag = 5'd7;
        @(posedge clk); #1; req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("hold_tag", {59'd0, resp_tag}, 64'd7);
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk); resp_ready = 1'b1; req_valid = 1'b1; #1;
        chk("hs_cycle_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1; resp_ready = 1'b0; req_valid = 1'b0; #1;
        chk("hs_after_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("hs_after_req_ready", {63'd0, req_ready}, 64'd1);

        // Flush together with resp_ready in DONE discards the result.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_src1 = 64'd9; req_src2 = 64'd0; req_tag = 5'd3;
        @(posedge clk); #1; req_valid = 1'b0;
        chk("fd_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("fd_data", resp_data, 64'd9);
        @(negedge clk); flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1; flush = 1'b0; resp_ready = 1'b0; #1;
        chk("fd_after_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("fd_after_req_ready", {63'd0, req_ready}, 64'd1);

        // Reset while BUSY returns to IDLE.
        issue_only(2'b00, 64'd555, 64'd11);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("rstbusy_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rstbusy_resp_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rstbusy_idle", {63'd0, req_ready}, 64'd1);
        run_req('{2'b00, 1'b0, 64'd555, 64'd11, 5'd13, 64'd50, 1'b1}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences the shared iterative divider for the execute stage and decodes RV64M DIV/DIVU/REM/REMU and their W forms.
- Resolves divide-by-zero and signed overflow locally; these never reach the divider.
- Serves a DIV/REM pair on identical operands from a one-entry result cache.
- Captures the divider's one-cycle result pulse and holds the selected, sign-extended result under a valid/ready response handshake. Supports pipeline flush.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 5, width of the opaque destination tag carried from request to response.
- USE_CACHE, 1, enables the operand-match result cache; 0 means every non-special op goes to the divider.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill the in-flight op and any held response
- req_valid  in  1  request valid
- req_ready  out  1  controller accepts a request this cycle
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_word  in  1  W variant: 32-bit operands, sign-extended result
- req_src1  in  64  dividend
- req_src2  in  64  divisor
- req_tag  in  TAG_W  destination tag
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes the result
- resp_data  out  64  result
- resp_tag  out  TAG_W  tag of the result
- div_valid  out  1  start pulse to the divider
- div_ready  in  1  divider idle
- div_divw  out  1  word mode to the divider
- div_signed  out  1  signed mode to the divider
- div_flush  out  1  abort to the divider
- div_dividend  out  64  operand to the divider
- div_divisor  out  64  operand to the divider
- div_out_valid  in  1  one-cycle result pulse from the divider
- div_quotient  in  64  divider quotient
- div_remainder  in  64  divider remainder

Behaviour:
- Reset values: state IDLE; req_ready 0 while rst is high; resp_valid 0; div_valid 0; div_flush 0; resp_data 0; resp_tag 0; cache valid 0.
- State machine:
  - IDLE: on accept with a special case or cache hit -> DONE; on accept otherwise -> BUSY.
  - BUSY: on div_out_valid -> DONE.
  - DONE: on resp_ready -> IDLE.
- req_ready = (state==IDLE) && div_ready && !flush. Accept = req_valid && req_ready.
- Operand view: for W ops, operands are src[31:0]. Signed ops are DIV and REM.
- Special cases (combinational), with result taken at accept:
  - Divisor zero: quotient all ones; remainder = dividend.
  - Signed, dividend = most-negative value and divisor = -1: quotient = dividend; remainder 0.
  - W results are computed on 32 bits, then sign-extended.
- Cache hit:
  - Condition: USE_CACHE && cache valid && same src1, src2, req_word and signedness as the stored entry.
  - Result is the stored quotient or remainder.
  - The cache holds {src1, src2, word, signed, quotient64, remainder64}. It is written only on div_out_valid; flush does not clear it.
- Divider issue:
  - On accept into BUSY, div_valid is high for exactly that cycle, with div_dividend=req_src1, div_divisor=req_src2, div_divw=req_word, div_signed=op signed.
  - Tag and op are registered.
- Completion:
  - Sample div_quotient/div_remainder on div_out_valid.
  - Select quotient for DIV/DIVU and remainder for REM/REMU.
  - For W ops, resp_data = sign-extend of the selected [31:0].
  - resp_valid rises the next cycle.
  - No fixed divider latency is assumed: 64-bit ops complete about 65 cycles after issue, W ops about 33.
- Fast-path latency: accept at cycle N -> resp_valid at N+1.
- Response holding: resp_valid, resp_data and resp_tag are held stable while resp_ready is low. resp_valid && resp_ready returns to IDLE, and a new accept is possible that same cycle only after the state update, i.e. the next cycle.
- Flush:
  - Has priority over everything: state -> IDLE next cycle and resp_valid drops.
  - A request presented in the same cycle is not accepted.
  - div_flush = flush && (state==BUSY), combinational.
  - div_out_valid arriving in the flush cycle is ignored, and neither the result register nor the cache is written.
- Simultaneous events: flush with resp_ready in DONE counts as a flush; the result is discarded, not consumed.
- Reset mid-BUSY: the controller returns to IDLE asynchronously. The divider is reset by the same rst.

Decomposition:
- Package div_ctrl_pkg: op encoding constants, state enum (IDLE, BUSY, DONE), the XLEN constant, and the most-negative constants for 64 and 32 bits.
- Sub-module div_special_case: combinational detection and result for divide-by-zero and overflow. Inputs: operands, op, word. Outputs: hit flag and 64-bit result.

Test Plan:
- DIV src1=-7, src2=2 -> one div_valid pulse; resp_data=0xFFFFFFFFFFFFFFFD. Then REM -7,2 via cache -> 0xFFFFFFFFFFFFFFFF at N+1, with no div_valid.
- DIVU 5/0 and REMU 5/0 -> 0xFFFFFFFFFFFFFFFF and 5 at N+1, with div_valid never asserted.
- DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000. REMW 0x0000000180000000 / 0xFFFFFFFF -> 0.
- DIVW 0x00000000FFFFFFF9 / 2 -> 0xFFFFFFFFFFFFFFFD. DIVUW 0xFFFFFFFF / 1 -> 0xFFFFFFFFFFFFFFFF (sign-extended).
- DIV 100/7 then flush 10 cycles into BUSY -> div_flush pulse, no resp_valid, IDLE next cycle. Then REM 100/7 -> divider issued (no cache hit), result 2.
- Result held with resp_ready low for 5 cycles -> resp_data and resp_tag stable; req_ready stays 0 until the handshake completes.
